dualmem_param: RTL

Parametrised true-dual-port byte-writable RAM, the successor to the fixed 64-bit × 2048 dual-port memory used for boot ROM/BRAM and shared buffers. Width, depth and read latency are configurable. Both ports share one clock. The block adds per-port read-valid flags, defined same-address collision resolution with forwarding, and a collision indicator. Its host-visible memory region is unchanged: it is a drop-in for the old block when clkb equals clka.

---
 rtl/dualmem_param_if.sv | 19 +
 rtl/dualmem_param.sv | 82 ++++++++
 2 files changed

// File: rtl/dualmem_param_if.sv
// dualmem_param_if: request and response signals of both RAM ports
interface dualmem_param_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 11
);
    logic                    ena, enb;
    logic [DATA_WIDTH/8-1:0] wea, web;
    logic [ADDR_WIDTH-1:0]   addra, addrb;
    logic [DATA_WIDTH-1:0]   dina, dinb, douta, doutb;
    logic                    douta_valid, doutb_valid, collision;
    modport master (
        output ena, wea, addra, dina, enb, web, addrb, dinb,
        input  douta, douta_valid, doutb, doutb_valid, collision
    );
    modport slave (
        input  ena, wea, addra, dina, enb, web, addrb, dinb,
        output douta, douta_valid, doutb, doutb_valid, collision
    );
endinterface

// File: rtl/dualmem_param.sv
// dualmem_param: true-dual-port byte-writable RAM with write-first reads, cross-port forwarding and collision flag
module dualmem_param #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 11,
    parameter int OUT_REG    = 0
) (
    input logic clk,
    input logic rstn,
    dualmem_param_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] mem_a, mem_b, rd_a, rd_b, q_a, q_b;
    logic [NB-1:0]         wr_a, wr_b;
    logic                  same, col_d, col_q, v_a, v_b;
    // write strobes (blocked during reset), same-address detect and merged read words
    always_comb begin
        same  = bus.ena && bus.enb && bus.addra == bus.addrb;
        wr_a  = (rstn && bus.ena) ? bus.wea : '0;
        wr_b  = (rstn && bus.enb) ? bus.web : '0;
        col_d = same && |(wr_a & wr_b);
        mem_a = mem[bus.addra];
        mem_b = mem[bus.addrb];
        rd_a  = mem_a;
        rd_b  = mem_b;
        for (int i = 0; i < NB; i++) begin
            rd_a[8*i+:8] = wr_a[i] ? bus.dina[8*i+:8] : (same && wr_b[i]) ? bus.dinb[8*i+:8] : mem_a[8*i+:8];
            rd_b[8*i+:8] = (same && wr_a[i]) ? bus.dina[8*i+:8] : wr_b[i] ? bus.dinb[8*i+:8] : mem_b[8*i+:8];
        end
    end
    // array update; port A owns any byte both ports write at the same address
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_b[i] && !(same && wr_a[i])) mem[bus.addrb][8*i+:8] <= bus.dinb[8*i+:8];
            if (wr_a[i]) mem[bus.addra][8*i+:8] <= bus.dina[8*i+:8];
        end
    end
    // first read stage: data holds while a port is idle, valid follows the enable
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_a   <= '0;
            q_b   <= '0;
            v_a   <= 1'b0;
            v_b   <= 1'b0;
            col_q <= 1'b0;
        end else begin
            if (bus.ena) q_a <= rd_a;
            if (bus.enb) q_b <= rd_b;
            v_a   <= bus.ena;
            v_b   <= bus.enb;
            col_q <= col_d;
        end
    end
    assign bus.collision = col_q;
    if (OUT_REG != 0) begin : g_reg
        logic [DATA_WIDTH-1:0] r_a, r_b;
        logic                  rv_a, rv_b;
        // optional second stage: data and valid re-registered together
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_a  <= '0;
                r_b  <= '0;
                rv_a <= 1'b0;
                rv_b <= 1'b0;
            end else begin
                if (v_a) r_a <= q_a;
                if (v_b) r_b <= q_b;
                rv_a <= v_a;
                rv_b <= v_b;
            end
        end
        assign bus.douta       = r_a;
        assign bus.doutb       = r_b;
        assign bus.douta_valid = rv_a;
        assign bus.doutb_valid = rv_b;
    end else begin : g_dir
        assign bus.douta       = q_a;
        assign bus.doutb       = q_b;
        assign bus.douta_valid = v_a;
        assign bus.doutb_valid = v_b;
    end
endmodule
